// File: rtl/mem_arbiter.sv
// Single-port memory arbiter with boot sequencer and fetch starvation guard.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          boot_req,
  input  logic [AW-1:0] boot_addr,
  input  logic [DW-1:0] boot_wdata,
  input  logic          boot_done,
  output logic          boot_gnt,
  output logic          cpu_hold,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   stat_if_cnt,
  output logic [31:0]   stat_d_cnt,
  output logic [31:0]   stat_conf_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] starve_cnt;
  logic          force_if;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == BOOT && boot_done) state_nx = RUN;
  end

  assign cpu_hold = (state == BOOT);
  assign force_if = if_req && (starve_cnt == SMAX);

  // grants are forced low while reset is asserted
  always_comb begin
    boot_gnt = 1'b0;
    if_gnt   = 1'b0;
    d_gnt    = 1'b0;
    if (reset) begin
      unique case (state)
        BOOT: boot_gnt = boot_req;
        RUN: begin
          d_gnt  = d_req && !force_if;
          if_gnt = if_req && !d_gnt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      boot_gnt: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = boot_addr;
        mem_wdata = boot_wdata;
      end
      d_gnt: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      if_gnt: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt && !d_we;
      if (state != RUN || !if_req || if_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != SMAX)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_if_cnt   <= '0;
      stat_d_cnt    <= '0;
      stat_conf_cnt <= '0;
    end else begin
      if (if_gnt && stat_if_cnt != '1)
        stat_if_cnt <= stat_if_cnt + 32'd1;
      if (d_gnt && stat_d_cnt != '1)
        stat_d_cnt <= stat_d_cnt + 32'd1;
      if (state == RUN && if_req && d_req && stat_conf_cnt != '1)
        stat_conf_cnt <= stat_conf_cnt + 32'd1;
    end
  end
`else
  assign stat_if_cnt   = '0;
  assign stat_d_cnt    = '0;
  assign stat_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter.
// Expects stats only when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

  logic        clk_tb;
  logic        reset;
  logic        boot_req, boot_done, boot_gnt, cpu_hold;
  logic [31:0] boot_addr, boot_wdata;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] stat_if_cnt, stat_d_cnt, stat_conf_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk_tb), .reset(reset),
    .boot_req(boot_req), .boot_addr(boot_addr),
    .boot_wdata(boot_wdata), .boot_done(boot_done),
    .boot_gnt(boot_gnt), .cpu_hold(cpu_hold),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_if_cnt(stat_if_cnt), .stat_d_cnt(stat_d_cnt),
    .stat_conf_cnt(stat_conf_cnt)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  typedef struct {
    logic        breq, bdone, ireq, dreq, dwe;
    logic [31:0] addr, wd, mrd;
    logic        bg, ig, dg, men, mwe, hold, irv, drv;
    logic [31:0] maddr, mwd;
  } vec_t;

  vec_t vec [12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    boot_req = 0; boot_done = 0; boot_addr = 0; boot_wdata = 0;
    if_req = 0; if_addr = 32'h1000;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_tb);
    idle();
    reset = 0;
    repeat (2) @(negedge clk_tb);
    reset = 1;
  endtask

  task automatic boot_to_run();
    @(negedge clk_tb);
    idle();
    boot_done = 1;
    @(negedge clk_tb);
    idle();
  endtask

  initial begin
    vec[0]  = '{1,0,1,1,0, 32'h0,  32'h2402000a, 0,
                1,0,0,1,1,1,0,0, 32'h0, 32'h2402000a};
    vec[1]  = '{1,0,1,1,0, 32'h4,  32'h2403000b, 0,
                1,0,0,1,1,1,0,0, 32'h4, 32'h2403000b};
    vec[2]  = '{1,1,1,1,0, 32'h8,  32'h2404000c, 0,
                1,0,0,1,1,1,0,0, 32'h8, 32'h2404000c};
    vec[3]  = '{1,0,0,0,0, 32'h40, 32'h77, 0,
                0,0,0,0,0,0,0,0, 32'h0, 32'h0};
    vec[4]  = '{0,0,0,1,0, 32'h10, 32'h0, 0,
                0,0,1,1,0,0,0,0, 32'h10, 32'h0};
    vec[5]  = '{0,0,0,0,0, 32'h0,  32'h0, 32'hdeadbeef,
                0,0,0,0,0,0,0,1, 32'h0, 32'h0};
    vec[6]  = '{0,0,1,0,0, 32'h0,  32'h0, 0,
                0,1,0,1,0,0,0,0, 32'h1000, 32'h0};
    vec[7]  = '{0,0,0,1,1, 32'h20, 32'h55aa, 32'h12345678,
                0,0,1,1,1,0,1,0, 32'h20, 32'h55aa};
    vec[8]  = '{0,0,0,0,0, 32'h0,  32'h0, 32'hcafe,
                0,0,0,0,0,0,0,0, 32'h0, 32'h0};
    vec[9]  = '{0,0,1,1,0, 32'h30, 32'h0, 0,
                0,0,1,1,0,0,0,0, 32'h30, 32'h0};
    vec[10] = '{0,0,1,0,0, 32'h0,  32'h0, 32'ha5a5,
                0,1,0,1,0,0,0,1, 32'h1000, 32'h0};
    vec[11] = '{0,0,0,0,0, 32'h0,  32'h0, 32'h5a5a,
                0,0,0,0,0,0,1,0, 32'h0, 32'h0};

    idle();
    reset = 0;
    boot_req = 1; if_req = 1; d_req = 1;
    repeat (2) @(negedge clk_tb);
    #1;
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_bgnt", 32'(boot_gnt), 0);
    check("rst_men", 32'(mem_en), 0);
    check("rst_irv", 32'(if_rvalid), 0);
    check("rst_drv", 32'(d_rvalid), 0);
    check("rst_stat", stat_d_cnt | stat_if_cnt | stat_conf_cnt, 0);
    reset = 1;
    idle();

    for (int i = 0; i < 12; i++) begin
      @(negedge clk_tb);
      boot_req = vec[i].breq; boot_done = vec[i].bdone;
      boot_addr = vec[i].addr; boot_wdata = vec[i].wd;
      if_req = vec[i].ireq; if_addr = 32'h1000;
      d_req = vec[i].dreq; d_we = vec[i].dwe;
      d_addr = vec[i].addr; d_wdata = vec[i].wd;
      mem_rdata = vec[i].mrd;
      #1;
      check($sformatf("v%0d_bgnt", i), 32'(boot_gnt), 32'(vec[i].bg));
      check($sformatf("v%0d_ignt", i), 32'(if_gnt), 32'(vec[i].ig));
      check($sformatf("v%0d_dgnt", i), 32'(d_gnt), 32'(vec[i].dg));
      check($sformatf("v%0d_men", i), 32'(mem_en), 32'(vec[i].men));
      check($sformatf("v%0d_mwe", i), 32'(mem_we), 32'(vec[i].mwe));
      check($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(vec[i].hold));
      check($sformatf("v%0d_irv", i), 32'(if_rvalid), 32'(vec[i].irv));
      check($sformatf("v%0d_drv", i), 32'(d_rvalid), 32'(vec[i].drv));
      check($sformatf("v%0d_maddr", i), mem_addr, vec[i].maddr);
      check($sformatf("v%0d_mwd", i), mem_wdata, vec[i].mwd);
      if (vec[i].drv)
        check($sformatf("v%0d_drd", i), d_rdata, vec[i].mrd);
      if (vec[i].irv)
        check($sformatf("v%0d_ird", i), if_rdata, vec[i].mrd);
    end

    // starvation under continuous contention, fresh stats
    do_reset();
    boot_to_run();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_tb);
      if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h80;
      #1;
      check($sformatf("starve%0d_ignt", k), 32'(if_gnt),
            (k == 4 || k == 9) ? 1 : 0);
      check($sformatf("starve%0d_dgnt", k), 32'(d_gnt),
            (k == 4 || k == 9) ? 0 : 1);
    end
    @(negedge clk_tb);
    idle();
    #1;
`ifdef MEM_ARB_STATS_EN
    check("stat_d", stat_d_cnt, 8);
    check("stat_if", stat_if_cnt, 2);
    check("stat_conf", stat_conf_cnt, 10);
`else
    check("stat_d", stat_d_cnt, 0);
    check("stat_if", stat_if_cnt, 0);
    check("stat_conf", stat_conf_cnt, 0);
`endif

    // reset lands between a fetch grant and its return
    @(negedge clk_tb);
    if_req = 1;
    #1;
    check("mid_ignt", 32'(if_gnt), 1);
    #1 reset = 0;
    #1;
    check("mid_ignt_rst", 32'(if_gnt), 0);
    check("mid_men_rst", 32'(mem_en), 0);
    @(posedge clk_tb);
    #1;
    check("mid_irv", 32'(if_rvalid), 0);
    check("mid_hold", 32'(cpu_hold), 1);
    @(negedge clk_tb);
    reset = 1;
    if_req = 0; d_req = 1;
    #1;
    check("mid_boot_dgnt", 32'(d_gnt), 0);
    check("mid_boot_hold", 32'(cpu_hold), 1);
    check("mid_irv2", 32'(if_rvalid), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
